decode: RTL and testbench
=========================

Name: decode

Overview:
- Second pipeline stage of the RV32I core. Consumes the fetch-to-decode bundle (instruction_value, pc_value).
- Decodes the instruction and generates the immediate.
- Reads the integer register file, which is held in a sub-module with a writeback write port.
- Registers the result into the decode-to-execute bundle.
- Detects load-use hazards: asks fetch to hold and inserts a bubble. Accepts a flush from execute on redirect.

Parameters:
- XLEN, 32, data/register width.
- NREGS, 32, architectural register count (x0 hardwired to zero).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- fe_to_de  input  fe_to_de_s  instruction_value[31:0], pc_value[31:0] from fetch.
- flush  input  1  execute-stage redirect; kill the instruction currently being decoded.
- wb_we  input  1  register-file write enable from writeback.
- wb_rd  input  5  writeback destination register.
- wb_data  input  XLEN  writeback data.
- stall_fe  output  1  combinational; fetch holds pc and fe_to_de while high.
- de_to_ex  output  de_to_ex_s  registered decoded bundle, described below.

Behaviour:
- de_to_ex fields:
  - valid, illegal.
  - pc_value, rs1_val, rs2_val, imm[31:0].
  - rs1, rs2, rd.
  - funct3, funct7b5.
  - alu_src_imm, reg_write, mem_read, mem_write, branch, jal, jalr, lui, auipc.
- Reset:
  - Synchronous: on a clk edge with reset=1, de_to_ex is cleared to all-zero (a bubble, valid=0).
  - Register file is cleared to zero.
  - stall_fe=0 while reset is high.
- Latency: fe_to_de sampled in cycle N appears on de_to_ex in cycle N+1.
- Bubble sources:
  - instruction_value==32'h0 (fetch post-reset value) produces valid=0 with all enables 0. It is not flagged illegal.
- Opcode classes:
  - Supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other non-zero opcode produces valid=1, illegal=1, and reg_write, mem_read, mem_write, branch, jal, jalr all 0.
- Immediates are sign-extended to 32 bits:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R-type: imm=0.
- Source usage:
  - uses_rs1 for JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2 for BRANCH, STORE, OP.
- Register read:
  - x0 always reads 0.
  - Write-through: if wb_we && wb_rd!=0 && wb_rd==rsN in the same cycle, rsN_val=wb_data.
  - Writes with wb_rd==0 are ignored.
- Load-use hazard (combinational):
  - Condition: de_to_ex.valid && de_to_ex.mem_read && de_to_ex.rd!=0 && ((uses_rs1 && rs1==de_to_ex.rd) || (uses_rs2 && rs2==de_to_ex.rd)).
  - Response: stall_fe=1 and next de_to_ex = bubble.
  - Stall lasts exactly one cycle per hazard. On the following cycle the held instruction re-decodes without hazard.
- Flush:
  - flush=1 means next de_to_ex = bubble and stall_fe=0.
  - Flush has priority over the hazard stall.
- Simultaneous wb write and hazard stall: the register file write still commits.
- Reset mid-stall: reset wins; bubble output, stall_fe=0.

Decomposition:
- Shared package riscv_structures:
  - de_to_ex_s typedef.
  - Opcode localparams (OPC_LUI=7'b0110111, OPC_AUIPC=7'b0010111, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111, OPC_BRANCH=7'b1100011, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_OPIMM=7'b0010011, OPC_OP=7'b0110011).
  - Immediate-format enum.
- Sub-module reg_file:
  - 2 asynchronous read ports, 1 synchronous write port, write-through, x0 zero, synchronous reset.

Test Plan:
- Reset: hold reset 2 cycles with fe_to_de=(32'h00500093, pc 0) -> de_to_ex all zero, stall_fe=0. First post-reset edge then gives valid=1, rd=1, imm=5, reg_write=1, alu_src_imm=1.
- Immediates:
  - 32'hFE000EE3 (beq x0,x0,-4) -> branch=1, imm=32'hFFFFFFFC.
  - 32'h123450B7 (lui x1) -> lui=1, imm=32'h12345000.
  - 32'h0080006F (jal x0,8) -> jal=1, imm=8.
- Write-through and x0: wb_we=1, wb_rd=3, wb_data=32'hDEADBEEF same cycle as add x4,x3,x0 -> rs1_val=32'hDEADBEEF, rs2_val=0. A wb to x0 is ignored and a later read of x0 gives 0.
- Load-use: lw x5,0(x1) followed by add x6,x5,x2 -> stall_fe=1 for one cycle, bubble in de_to_ex, then add issues valid. With add x6,x7,x2 instead -> no stall.
- Flush priority: flush=1 during a load-use hazard cycle -> stall_fe=0, de_to_ex.valid=0 next cycle.
- Illegal and bubble: opcode 7'b1111111 -> valid=1, illegal=1, all enables 0. instruction 32'h0 -> valid=0, illegal=0.

Source files
------------

// File: rtl/riscv_structures.sv
// Shared RV32I pipeline types: opcode constants, immediate formats and the
// fetch/decode/execute stage bundles.
package riscv_structures;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] instruction_value;
    logic [31:0] pc_value;
  } fe_to_de_s;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] pc_value;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
  } de_to_ex_s;

  // All formats sign-extend from inst[31]; R-type carries no immediate.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two asynchronous read ports with write-through from
// the single synchronous write port; x0 is hardwired to zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && wr_addr != 5'd0) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // A write landing this cycle is forwarded so decode never sees stale data.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (we && wr_addr != 5'd0 && wr_addr == rs1_addr) rs1_data = wr_data;
    if (rs1_addr == 5'd0) rs1_data = '0;

    rs2_data = regs_q[rs2_addr];
    if (we && wr_addr != 5'd0 && wr_addr == rs2_addr) rs2_data = wr_data;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: instruction decode, immediate generation, register read,
// load-use hazard detection and flush handling into the de_to_ex register.
module decode
  import riscv_structures::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  fe_to_de_s       fe_to_de,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_fe,
  output de_to_ex_s       de_to_ex
);

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  imm_fmt_e        fmt;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            hazard;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  de_to_ex_s       dec;
  de_to_ex_s       de_to_ex_d;
  de_to_ex_s       de_to_ex_q;

  assign inst   = fe_to_de.instruction_value;
  assign opcode = inst[6:0];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  reg_file #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .rs1_addr(rs1),
    .rs2_addr(rs2),
    .rs1_data(rs1_val),
    .rs2_data(rs2_val),
    .we      (wb_we),
    .wr_addr (wb_rd),
    .wr_data (wb_data)
  );

  always_comb begin
    dec          = '0;
    fmt          = IMM_R;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    dec.valid    = (inst != 32'h0);
    dec.pc_value = fe_to_de.pc_value;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = inst[11:7];
    dec.funct3   = inst[14:12];
    dec.funct7b5 = inst[30];
    dec.rs1_val  = rs1_val;
    dec.rs2_val  = rs2_val;
    case (opcode)
      OPC_LUI:    begin fmt = IMM_U; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.lui = 1'b1; end
      OPC_AUIPC:  begin fmt = IMM_U; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.auipc = 1'b1; end
      OPC_JAL:    begin fmt = IMM_J; dec.reg_write = 1'b1; dec.jal = 1'b1; end
      OPC_JALR:   begin fmt = IMM_I; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.jalr = 1'b1; uses_rs1 = 1'b1; end
      OPC_BRANCH: begin fmt = IMM_B; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_LOAD:   begin fmt = IMM_I; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.mem_read = 1'b1; uses_rs1 = 1'b1; end
      OPC_STORE:  begin fmt = IMM_S; dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OPIMM:  begin fmt = IMM_I; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; uses_rs1 = 1'b1; end
      OPC_OP:     begin fmt = IMM_R; dec.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:    dec.illegal = dec.valid;
    endcase
    dec.imm = gen_imm(inst, fmt);
    // rd is only meaningful when the instruction writes back; zero it otherwise
    // so downstream hazard checks cannot match on immediate bits.
    if (!dec.reg_write) dec.rd = 5'd0;
    if (!dec.valid) dec = '0;
  end

  always_comb begin
    hazard = de_to_ex_q.valid && de_to_ex_q.mem_read && (de_to_ex_q.rd != 5'd0) &&
             ((uses_rs1 && rs1 == de_to_ex_q.rd) || (uses_rs2 && rs2 == de_to_ex_q.rd));
    stall_fe   = hazard && !flush && !reset;
    de_to_ex_d = (flush || hazard) ? '0 : dec;
  end

  always_ff @(posedge clk) begin
    if (reset) de_to_ex_q <= '0;
    else       de_to_ex_q <= de_to_ex_d;
  end

  assign de_to_ex = de_to_ex_q;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode stage: reset, immediates,
// register read/write-through, load-use stall, flush priority and illegal ops.
module tb_decode;
  import riscv_structures::*;

  logic        clk;
  logic        reset;
  fe_to_de_s   fe_to_de;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_fe;
  de_to_ex_s   de_to_ex;

  int assertions;
  int failures;

  decode #(.XLEN(32), .NREGS(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .fe_to_de(fe_to_de),
    .flush   (flush),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .stall_fe(stall_fe),
    .de_to_ex(de_to_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    fe_to_de.instruction_value = inst;
    fe_to_de.pc_value          = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    present(32'h00500093, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      assertions++; if (de_to_ex !== '0) begin failures++; $display("[TB] FAIL reset_bundle cycle %0d: got %h expected 0", i, de_to_ex); end
      assertions++; if (stall_fe !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall cycle %0d: got %b expected 0", i, stall_fe); end
    end
    reset = 1'b0;
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.illegal, de_to_ex.reg_write, de_to_ex.alu_src_imm} !== 4'b1011) begin failures++; $display("[TB] FAIL addi_flags: got %b expected 1011", {de_to_ex.valid, de_to_ex.illegal, de_to_ex.reg_write, de_to_ex.alu_src_imm}); end
    assertions++; if (de_to_ex.rd !== 5'd1) begin failures++; $display("[TB] FAIL addi_rd: got %0d expected 1", de_to_ex.rd); end
    assertions++; if (de_to_ex.imm !== 32'd5) begin failures++; $display("[TB] FAIL addi_imm: got %h expected 5", de_to_ex.imm); end
  endtask

  task automatic test_immediates();
    present(32'hFE000EE3, 32'h40);
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.branch, de_to_ex.reg_write} !== 3'b110) begin failures++; $display("[TB] FAIL beq_flags: got %b expected 110", {de_to_ex.valid, de_to_ex.branch, de_to_ex.reg_write}); end
    assertions++; if (de_to_ex.imm !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL beq_imm: got %h expected fffffffc", de_to_ex.imm); end
    present(32'h123450B7, 32'h44);
    tick();
    assertions++; if ({de_to_ex.lui, de_to_ex.reg_write, de_to_ex.rd} !== {2'b11, 5'd1}) begin failures++; $display("[TB] FAIL lui_flags: got %b expected 1100001", {de_to_ex.lui, de_to_ex.reg_write, de_to_ex.rd}); end
    assertions++; if (de_to_ex.imm !== 32'h12345000) begin failures++; $display("[TB] FAIL lui_imm: got %h expected 12345000", de_to_ex.imm); end
    present(32'h0080006F, 32'h100);
    tick();
    assertions++; if ({de_to_ex.jal, de_to_ex.jalr, de_to_ex.branch} !== 3'b100) begin failures++; $display("[TB] FAIL jal_flags: got %b expected 100", {de_to_ex.jal, de_to_ex.jalr, de_to_ex.branch}); end
    assertions++; if (de_to_ex.imm !== 32'd8) begin failures++; $display("[TB] FAIL jal_imm: got %h expected 8", de_to_ex.imm); end
    assertions++; if (de_to_ex.pc_value !== 32'h100) begin failures++; $display("[TB] FAIL jal_pc: got %h expected 100", de_to_ex.pc_value); end
    present(32'h0020A623, 32'h104);
    tick();
    assertions++; if ({de_to_ex.mem_write, de_to_ex.mem_read, de_to_ex.reg_write} !== 3'b100) begin failures++; $display("[TB] FAIL sw_flags: got %b expected 100", {de_to_ex.mem_write, de_to_ex.mem_read, de_to_ex.reg_write}); end
    assertions++; if (de_to_ex.imm !== 32'd12) begin failures++; $display("[TB] FAIL sw_imm: got %h expected c", de_to_ex.imm); end
  endtask

  task automatic test_write_through();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    present(32'h00018233, 32'h200);
    tick();
    wb_we = 1'b0;
    assertions++; if (de_to_ex.rs1_val !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wt_rs1: got %h expected deadbeef", de_to_ex.rs1_val); end
    assertions++; if (de_to_ex.rs2_val !== 32'h0) begin failures++; $display("[TB] FAIL wt_rs2: got %h expected 0", de_to_ex.rs2_val); end
    assertions++; if (de_to_ex.rd !== 5'd4) begin failures++; $display("[TB] FAIL wt_rd: got %0d expected 4", de_to_ex.rd); end
    tick();
    assertions++; if (de_to_ex.rs1_val !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL stored_rs1: got %h expected deadbeef", de_to_ex.rs1_val); end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    present(32'h00000233, 32'h204);
    tick();
    wb_we = 1'b0;
    assertions++; if (de_to_ex.rs1_val !== 32'h0) begin failures++; $display("[TB] FAIL x0_wt: got %h expected 0", de_to_ex.rs1_val); end
    tick();
    assertions++; if ({de_to_ex.rs1_val, de_to_ex.rs2_val} !== 64'h0) begin failures++; $display("[TB] FAIL x0_read: got %h expected 0", {de_to_ex.rs1_val, de_to_ex.rs2_val}); end
  endtask

  task automatic test_load_use();
    present(32'h0000A283, 32'h300);
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.mem_read, de_to_ex.rd} !== {2'b11, 5'd5}) begin failures++; $display("[TB] FAIL lw_issue: got %b expected 1100101", {de_to_ex.valid, de_to_ex.mem_read, de_to_ex.rd}); end
    present(32'h00228333, 32'h304);
    #1;
    assertions++; if (stall_fe !== 1'b1) begin failures++; $display("[TB] FAIL lu_rs1_stall: got %b expected 1", stall_fe); end
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hCAFE0002;
    tick();
    wb_we = 1'b0;
    assertions++; if (de_to_ex.valid !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble: got %b expected 0", de_to_ex.valid); end
    assertions++; if (stall_fe !== 1'b0) begin failures++; $display("[TB] FAIL lu_one_cycle: got %b expected 0", stall_fe); end
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.rd, de_to_ex.rs1} !== {1'b1, 5'd6, 5'd5}) begin failures++; $display("[TB] FAIL lu_reissue: got %b expected 10011000101", {de_to_ex.valid, de_to_ex.rd, de_to_ex.rs1}); end
    assertions++; if (de_to_ex.rs2_val !== 32'hCAFE0002) begin failures++; $display("[TB] FAIL lu_wb_commit: got %h expected cafe0002", de_to_ex.rs2_val); end

    present(32'h0000A283, 32'h308);
    tick();
    present(32'h00510333, 32'h30C);
    #1;
    assertions++; if (stall_fe !== 1'b1) begin failures++; $display("[TB] FAIL lu_rs2_stall: got %b expected 1", stall_fe); end
    tick();
    tick();

    present(32'h0000A283, 32'h310);
    tick();
    present(32'h00238333, 32'h314);
    #1;
    assertions++; if (stall_fe !== 1'b0) begin failures++; $display("[TB] FAIL no_dep_stall: got %b expected 0", stall_fe); end
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.rd} !== {1'b1, 5'd6}) begin failures++; $display("[TB] FAIL no_dep_issue: got %b expected 100110", {de_to_ex.valid, de_to_ex.rd}); end
  endtask

  task automatic test_flush();
    present(32'h0000A283, 32'h400);
    tick();
    present(32'h00228333, 32'h404);
    flush = 1'b1;
    #1;
    assertions++; if (stall_fe !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall: got %b expected 0", stall_fe); end
    tick();
    flush = 1'b0;
    assertions++; if (de_to_ex.valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_bubble: got %b expected 0", de_to_ex.valid); end
    present(32'h00500093, 32'h408);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    assertions++; if (de_to_ex !== '0) begin failures++; $display("[TB] FAIL flush_plain: got %h expected 0", de_to_ex); end
  endtask

  task automatic test_illegal();
    present(32'h0000007F, 32'h500);
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.illegal} !== 2'b11) begin failures++; $display("[TB] FAIL illegal_flags: got %b expected 11", {de_to_ex.valid, de_to_ex.illegal}); end
    assertions++; if ({de_to_ex.reg_write, de_to_ex.mem_read, de_to_ex.mem_write, de_to_ex.branch, de_to_ex.jal, de_to_ex.jalr} !== 6'b0) begin failures++; $display("[TB] FAIL illegal_enables: got %b expected 000000", {de_to_ex.reg_write, de_to_ex.mem_read, de_to_ex.mem_write, de_to_ex.branch, de_to_ex.jal, de_to_ex.jalr}); end
    present(32'h00000000, 32'h504);
    tick();
    assertions++; if ({de_to_ex.valid, de_to_ex.illegal, de_to_ex.reg_write} !== 3'b000) begin failures++; $display("[TB] FAIL zero_bubble: got %b expected 000", {de_to_ex.valid, de_to_ex.illegal, de_to_ex.reg_write}); end
  endtask

  task automatic test_reset_mid_stall();
    present(32'h0000A283, 32'h600);
    tick();
    present(32'h00228333, 32'h604);
    #1;
    assertions++; if (stall_fe !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_stall: got %b expected 1", stall_fe); end
    reset = 1'b1;
    #1;
    assertions++; if (stall_fe !== 1'b0) begin failures++; $display("[TB] FAIL reset_kills_stall: got %b expected 0", stall_fe); end
    tick();
    reset = 1'b0;
    assertions++; if (de_to_ex !== '0) begin failures++; $display("[TB] FAIL reset_mid_stall_bundle: got %h expected 0", de_to_ex); end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    wb_we      = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 32'h0;
    present(32'h0, 32'h0);
    test_reset();
    test_immediates();
    test_write_through();
    test_load_use();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
